// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the single-issue RV32I core.
// It fetches one instruction at a time, decodes the opcode, drives the ALU operation
// code and the register-file write strobe, and runs loads and stores on the data port.
// It owns the PC and the instruction register.
//
// Ports:
//   clk, reset        - rising-edge clock; asynchronous active-low reset
//   imem_*            - fetch port: req_valid/req_ready handshake, addr (= pc),
//                       rvalid/rdata response
//   dmem_*            - data port: req_valid/req_ready handshake, we (1 = store),
//                       rvalid response for loads
//   take_branch,
//   target_pc         - redirect from the datapath, sampled in EXEC
//   pc, inst          - current instruction PC and instruction register
//   alu_ctrl          - ALU operation code, held from DECODE through WB
//   rf_we             - register-file write strobe, one pulse per writing instruction
//   halt, trap,
//   trap_cause        - sticky terminal status (cause 01 illegal, 10 misaligned target)
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  input  logic        dmem_rvalid,
  input  logic        take_branch,
  input  logic [31:0] target_pc,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [3:0]  alu_ctrl,
  output logic        rf_we,
  output logic        halt,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [6:0]  OpcOp     = 7'b0110011;
  localparam logic [6:0]  OpcOpImm  = 7'b0010011;
  localparam logic [6:0]  OpcLui    = 7'b0110111;
  localparam logic [6:0]  OpcAuipc  = 7'b0010111;
  localparam logic [6:0]  OpcJal    = 7'b1101111;
  localparam logic [6:0]  OpcJalr   = 7'b1100111;
  localparam logic [6:0]  OpcBranch = 7'b1100011;
  localparam logic [6:0]  OpcLoad   = 7'b0000011;
  localparam logic [6:0]  OpcStore  = 7'b0100011;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstNop    = 32'h0000_0013;

  localparam logic [1:0] CauseNone      = 2'b00;
  localparam logic [1:0] CauseIllegal   = 2'b01;
  localparam logic [1:0] CauseMisalign  = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StIwait,
    StDecode,
    StExec,
    StMem,
    StMwait,
    StWb,
    StHalt,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;
  logic        imem_req_valid_q, imem_req_valid_d;
  logic        dmem_req_valid_q, dmem_req_valid_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        halt_q, halt_d;
  logic        trap_q, trap_d;
  logic [1:0]  trap_cause_q, trap_cause_d;

  // Decode of the instruction register; inst_q is stable from DECODE until the
  // next fetch response, so these are valid for every state that consults them.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_branch, is_load, is_store, is_ebreak, is_legal, writes_rd;
  logic [3:0] alu_dec;

  assign opcode    = inst_q[6:0];
  assign funct3    = inst_q[14:12];
  assign is_op     = (opcode == OpcOp);
  assign is_opimm  = (opcode == OpcOpImm);
  assign is_lui    = (opcode == OpcLui);
  assign is_auipc  = (opcode == OpcAuipc);
  assign is_jal    = (opcode == OpcJal);
  assign is_jalr   = (opcode == OpcJalr);
  assign is_branch = (opcode == OpcBranch);
  assign is_load   = (opcode == OpcLoad);
  assign is_store  = (opcode == OpcStore);
  assign is_ebreak = (inst_q == InstEbreak);
  assign is_legal  = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr |
                     is_branch | is_load | is_store;
  assign writes_rd = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr | is_load;

  always_comb begin
    alu_dec = 4'b0000;
    if (is_op) begin
      alu_dec = {inst_q[30], funct3};
    end else if (is_opimm) begin
      // inst[30] only selects SRAI over SRLI; for other immediates it is data.
      alu_dec = {inst_q[30] & (funct3 == 3'b101), funct3};
    end else if (is_branch) begin
      alu_dec = 4'b1000;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    alu_ctrl_d   = alu_ctrl_q;
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
    trap_cause_d = trap_cause_q;

    unique case (state_q)
      StFetch: begin
        if (imem_req_valid_q && imem_req_ready) state_d = StIwait;
      end
      StIwait: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_ebreak) begin
          state_d = StHalt;
        end else if (!is_legal) begin
          state_d      = StTrap;
          trap_cause_d = CauseIllegal;
        end else begin
          alu_ctrl_d = alu_dec;
          state_d    = StExec;
        end
      end
      StExec: begin
        br_taken_d  = take_branch;
        br_target_d = target_pc;
        if (take_branch && (target_pc[1:0] != 2'b00)) begin
          state_d      = StTrap;
          trap_cause_d = CauseMisalign;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_req_valid_q && dmem_req_ready) state_d = is_store ? StWb : StMwait;
      end
      StMwait: begin
        if (dmem_rvalid) state_d = StWb;
      end
      StWb: begin
        pc_d    = br_taken_q ? br_target_q : pc_q + 32'd4;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // Outputs are registered off the next state so they are glitch-free and all
    // drop to zero during reset (imem_req_valid rises one cycle after release).
    imem_req_valid_d = (state_d == StFetch);
    dmem_req_valid_d = (state_d == StMem);
    dmem_we_d        = (state_d == StMem) && is_store;
    rf_we_d          = (state_d == StWb) && writes_rd;
    halt_d           = halt_q | (state_d == StHalt);
    trap_d           = trap_q | (state_d == StTrap);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StFetch;
      pc_q             <= RESET_PC;
      inst_q           <= InstNop;
      alu_ctrl_q       <= 4'b0000;
      br_taken_q       <= 1'b0;
      br_target_q      <= 32'h0000_0000;
      imem_req_valid_q <= 1'b0;
      dmem_req_valid_q <= 1'b0;
      dmem_we_q        <= 1'b0;
      rf_we_q          <= 1'b0;
      halt_q           <= 1'b0;
      trap_q           <= 1'b0;
      trap_cause_q     <= CauseNone;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inst_q           <= inst_d;
      alu_ctrl_q       <= alu_ctrl_d;
      br_taken_q       <= br_taken_d;
      br_target_q      <= br_target_d;
      imem_req_valid_q <= imem_req_valid_d;
      dmem_req_valid_q <= dmem_req_valid_d;
      dmem_we_q        <= dmem_we_d;
      rf_we_q          <= rf_we_d;
      halt_q           <= halt_d;
      trap_q           <= trap_d;
      trap_cause_q     <= trap_cause_d;
    end
  end

  assign imem_req_valid = imem_req_valid_q;
  assign imem_addr      = pc_q;
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_we        = dmem_we_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign alu_ctrl       = alu_ctrl_q;
  assign rf_we          = rf_we_q;
  assign halt           = halt_q;
  assign trap           = trap_q;
  assign trap_cause     = trap_cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
  logic        take_branch;
  logic [31:0] target_pc;
  logic [31:0] pc, inst;
  logic [3:0]  alu_ctrl;
  logic        rf_we, halt, trap;
  logic [1:0]  trap_cause;

  int errors = 0;
  int checks = 0;

  core_seq_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .take_branch(take_branch), .target_pc(target_pc),
    .pc(pc), .inst(inst), .alu_ctrl(alu_ctrl), .rf_we(rf_we),
    .halt(halt), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Results of the last run_instr call. Cycle 1 is the first FETCH cycle.
  int          r_len, r_rf_cnt, r_rf_cyc;
  bit          r_dm_seen, r_dm_we, r_addr_ok, r_halt, r_trap, r_timeout;
  logic [3:0]  r_alu;
  logic [31:0] r_addr;
  logic [1:0]  r_cause;

  task automatic clear_inputs();
    imem_req_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Plays the memories for one instruction, starting at a negedge. Inputs are
  // driven and outputs sampled on negedges only.
  task automatic run_instr(input logic [31:0] instr, input int ireq_stall, input int irv_dly,
                           input int dreq_stall, input int drv_dly, input logic tb_take,
                           input logic [31:0] tb_tgt, input int abort_at);
    int cyc = 0;
    int is = ireq_stall, ir = irv_dly, ds = dreq_stall, dr = drv_dly;
    int wait_n = 0;
    bit ipend = 0, dpend = 0, fetched = 0, dsent = 0, done = 0;
    r_len = 0; r_rf_cnt = 0; r_rf_cyc = 0; r_dm_seen = 0; r_dm_we = 0;
    r_addr_ok = 1; r_halt = 0; r_trap = 0; r_timeout = 0; r_alu = 4'hx; r_cause = 2'b00;
    take_branch = tb_take; target_pc = tb_tgt;
    while (!imem_req_valid && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!imem_req_valid) begin
      r_timeout = 1;
      return;
    end
    r_addr = imem_addr;
    while (cyc < 60 && !done) begin
      cyc++;
      if (fetched && imem_req_valid) begin
        r_len = cyc - 1; done = 1;
      end else if (halt || trap) begin
        r_len = cyc; r_halt = halt; r_trap = trap; r_cause = trap_cause; done = 1;
      end else if (abort_at == cyc) begin
        reset = 1'b0; done = 1;
      end else begin
        if (imem_req_valid && imem_addr !== r_addr) r_addr_ok = 0;
        if (rf_we) begin r_rf_cnt++; r_rf_cyc = cyc; end
        if (dmem_req_valid) begin r_dm_seen = 1; r_dm_we = dmem_we; end
        r_alu = alu_ctrl;
        clear_inputs();
        if (ipend) begin
          if (ir > 0) ir--;
          else begin imem_rvalid = 1'b1; imem_rdata = instr; ipend = 0; end
        end else if (imem_req_valid && !fetched) begin
          if (is > 0) is--;
          else begin imem_req_ready = 1'b1; ipend = 1; fetched = 1; end
        end
        if (dpend) begin
          if (dr > 0) dr--;
          else begin dmem_rvalid = 1'b1; dpend = 0; end
        end else if (dmem_req_valid && !dsent) begin
          if (ds > 0) ds--;
          else begin dmem_req_ready = 1'b1; dsent = 1; dpend = !dmem_we; end
        end
        @(negedge clk);
      end
    end
    if (!done) r_timeout = 1;
    clear_inputs();
    take_branch = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    take_branch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12 reset = 1'b0;
    #1;
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
    checks++; if (inst !== 32'h13) begin errors++; $display("FAIL rst_inst: got %h want 00000013", inst); end
    checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL rst_alu: got %h want 0", alu_ctrl); end
    checks++; if ({rf_we, imem_req_valid, dmem_req_valid, dmem_we} !== 4'b0000) begin
      errors++; $display("FAIL rst_strobes: got %b want 0000", {rf_we, imem_req_valid, dmem_req_valid, dmem_we});
    end
    checks++; if ({halt, trap, trap_cause} !== 4'b0000) begin
      errors++; $display("FAIL rst_status: got %b want 0000", {halt, trap, trap_cause});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid: got %b want 0", imem_req_valid); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL rst_first_fetch: got %b/%h want 1/%h", imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_alu();
    run_instr(32'h0010_0093, 0, 0, 0, 0, 1'b0, 32'h0, -1);  // addi x1,x0,1
    checks++; if (r_timeout) begin errors++; $display("FAIL addi_timeout: got 1 want 0"); end
    checks++; if (r_len !== 5) begin errors++; $display("FAIL addi_len: got %0d want 5", r_len); end
    checks++; if (r_rf_cnt !== 1 || r_rf_cyc !== 5) begin
      errors++; $display("FAIL addi_rf_we: got cnt %0d cyc %0d want 1/5", r_rf_cnt, r_rf_cyc);
    end
    checks++; if (r_alu !== 4'b0000) begin errors++; $display("FAIL addi_alu: got %b want 0000", r_alu); end
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL addi_pc: got %h want 80000004", pc); end
    run_instr(32'h4020_80B3, 3, 0, 0, 0, 1'b0, 32'h0, -1);  // sub, 3 stall cycles
    checks++; if (r_len !== 8 || r_rf_cyc !== 8) begin
      errors++; $display("FAIL sub_timing: got len %0d rf %0d want 8/8", r_len, r_rf_cyc);
    end
    checks++; if (r_alu !== 4'b1000) begin errors++; $display("FAIL sub_alu: got %b want 1000", r_alu); end
    checks++; if (!r_addr_ok || r_addr !== 32'h8000_0004) begin
      errors++; $display("FAIL sub_addr_stable: got %h ok=%0d want 80000004 ok=1", r_addr, r_addr_ok);
    end
  endtask

  task automatic test_mem();
    run_instr(32'h0000_2103, 0, 0, 0, 2, 1'b0, 32'h0, -1);  // lw, rvalid 2 late
    checks++; if (r_len !== 9 || r_rf_cnt !== 1 || r_rf_cyc !== 9) begin
      errors++; $display("FAIL load_slow: got len %0d cnt %0d rf %0d want 9/1/9", r_len, r_rf_cnt, r_rf_cyc);
    end
    checks++; if (r_dm_seen !== 1 || r_dm_we !== 0) begin
      errors++; $display("FAIL load_we: got seen %0d we %0d want 1/0", r_dm_seen, r_dm_we);
    end
    run_instr(32'h0020_A023, 0, 0, 0, 0, 1'b0, 32'h0, -1);  // sw
    checks++; if (r_len !== 6 || r_rf_cnt !== 0) begin
      errors++; $display("FAIL store: got len %0d rf %0d want 6/0", r_len, r_rf_cnt);
    end
    checks++; if (r_dm_seen !== 1 || r_dm_we !== 1) begin
      errors++; $display("FAIL store_we: got seen %0d we %0d want 1/1", r_dm_seen, r_dm_we);
    end
    run_instr(32'h0000_2103, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    checks++; if (r_len !== 7 || r_rf_cyc !== 7) begin
      errors++; $display("FAIL load_fast: got len %0d rf %0d want 7/7", r_len, r_rf_cyc);
    end
    run_instr(32'h0020_A023, 0, 0, 2, 0, 1'b0, 32'h0, -1);  // sw, ready 2 late
    checks++; if (r_len !== 8) begin errors++; $display("FAIL store_stall: got %0d want 8", r_len); end
    checks++; if (pc !== 32'h8000_0018) begin errors++; $display("FAIL mem_pc: got %h want 80000018", pc); end
  endtask

  task automatic test_branch();
    bit quiet = 1;
    run_instr(32'h0000_0063, 0, 0, 0, 0, 1'b1, 32'h8000_0100, -1);  // beq taken
    checks++; if (r_len !== 5 || r_rf_cnt !== 0 || r_alu !== 4'b1000) begin
      errors++; $display("FAIL beq: got len %0d rf %0d alu %b want 5/0/1000", r_len, r_rf_cnt, r_alu);
    end
    checks++; if (imem_addr !== 32'h8000_0100) begin
      errors++; $display("FAIL beq_target: got %h want 80000100", imem_addr);
    end
    run_instr(32'h0000_006F, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFFC, -1);  // jal to top of memory
    checks++; if (r_rf_cnt !== 1 || pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL jal: got rf %0d pc %h want 1/fffffffc", r_rf_cnt, pc);
    end
    run_instr(32'h0010_0093, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    checks++; if (r_addr !== 32'hFFFF_FFFC || pc !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: got fetch %h pc %h want fffffffc/00000000", r_addr, pc);
    end
    run_instr(32'h0000_0063, 0, 0, 0, 0, 1'b1, 32'h8000_0102, -1);  // misaligned target
    checks++; if (r_trap !== 1 || r_cause !== 2'b10 || r_len !== 5) begin
      errors++; $display("FAIL misalign: got trap %0d cause %b at %0d want 1/10/5", r_trap, r_cause, r_len);
    end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL misalign_pc: got %h want 00000000", pc); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid || dmem_req_valid || rf_we) quiet = 0;
    end
    checks++; if (!quiet || trap !== 1'b1) begin
      errors++; $display("FAIL misalign_quiet: got quiet %0d trap %b want 1/1", quiet, trap);
    end
  endtask

  task automatic test_trap_halt();
    bit quiet = 1;
    do_reset();
    run_instr(32'hFFFF_FFFF, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    checks++; if (r_trap !== 1 || r_cause !== 2'b01 || r_halt !== 0 || r_len !== 4) begin
      errors++; $display("FAIL illegal: got trap %0d cause %b halt %0d at %0d want 1/01/0/4",
                         r_trap, r_cause, r_halt, r_len);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid || dmem_req_valid || rf_we) quiet = 0;
    end
    checks++; if (!quiet || pc !== RST_PC) begin
      errors++; $display("FAIL illegal_quiet: got quiet %0d pc %h want 1/%h", quiet, pc, RST_PC);
    end
    do_reset();
    run_instr(32'h0000_0073, 0, 0, 0, 0, 1'b0, 32'h0, -1);  // ecall: not EBREAK
    checks++; if (r_trap !== 1 || r_cause !== 2'b01) begin
      errors++; $display("FAIL ecall: got trap %0d cause %b want 1/01", r_trap, r_cause);
    end
    do_reset();
    run_instr(32'h0010_0073, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    checks++; if (r_halt !== 1 || r_trap !== 0 || r_len !== 4) begin
      errors++; $display("FAIL ebreak: got halt %0d trap %0d at %0d want 1/0/4", r_halt, r_trap, r_len);
    end
    @(negedge clk);
    checks++; if (halt !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL halt_sticky: got halt %b req %b want 1/0", halt, imem_req_valid);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    run_instr(32'h0010_0093, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0000_2103, 0, 0, 0, 10, 1'b0, 32'h0, 7);  // reset lands in MWAIT
    #1;
    checks++; if (pc !== RST_PC || rf_we !== 1'b0) begin
      errors++; $display("FAIL abort_pc: got %h rf %b want %h/0", pc, rf_we, RST_PC);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dmem_rvalid = 1'b1;  // late response from the aborted load
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checks++; if (rf_we !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL abort_restart: got rf %b req %b addr %h want 0/1/%h",
                         rf_we, imem_req_valid, imem_addr, RST_PC);
    end
    run_instr(32'h0010_0093, 0, 0, 0, 0, 1'b0, 32'h0, -1);
    checks++; if (r_len !== 5 || r_rf_cnt !== 1 || pc !== 32'h8000_0004) begin
      errors++; $display("FAIL abort_next: got len %0d rf %0d pc %h want 5/1/80000004",
                         r_len, r_rf_cnt, pc);
    end
  endtask

  initial begin
    clear_inputs();
    take_branch = 1'b0;
    target_pc = 32'h0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_trap_halt();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle instruction sequencer for the single-issue RV32I core. It fetches instructions over a valid/ready instruction-memory port, decodes the opcode, drives the ALU control code and register-file write strobe, and sequences load/store accesses over a data-memory port. It owns the PC and instruction register and feeds `inst` to the immediate generator, register file and ALU datapath.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC value loaded on reset
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  instruction memory accepts request
- `imem_addr`  out  32  fetch address (= `pc`)
- `imem_rvalid`  in  1  fetch data valid
- `imem_rdata`  in  32  fetched instruction
- `dmem_req_valid`  out  1  load/store request valid
- `dmem_req_ready`  in  1  data memory accepts request
- `dmem_we`  out  1  1 = store, 0 = load; valid with `dmem_req_valid`
- `dmem_rvalid`  in  1  load data valid
- `take_branch`  in  1  datapath: taken branch or jump, valid in EXEC
- `target_pc`  in  32  datapath: redirect target, valid in EXEC
- `pc`  out  32  current instruction PC
- `inst`  out  32  instruction register
- `alu_ctrl`  out  4  ALU operation code
- `rf_we`  out  1  register-file write strobe, one-cycle pulse
- `halt`  out  1  sticky, EBREAK retired
- `trap`  out  1  sticky, fault detected
- `trap_cause`  out  2  01 illegal opcode, 10 misaligned target; 00 otherwise

## Operation
- States: FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT, TRAP.
- FETCH: `imem_req_valid`=1, held until `imem_req_ready`=1 -> IWAIT.
- IWAIT: on `imem_rvalid`, `inst` <= `imem_rdata` -> DECODE. `imem_rvalid` outside IWAIT is ignored.
- DECODE: opcode = `inst[6:0]`. Legal: 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, and exactly 32'h0010_0073 (EBREAK). Anything else -> TRAP, cause 01. EBREAK -> HALT.
- `alu_ctrl` (registered in DECODE, held through WB): OP = {`inst[30]`, `inst[14:12]`}; OP-IMM = {`inst[30]` & (funct3==101), funct3}; BRANCH = 4'b1000; all others 4'b0000 (ADD).
- EXEC: one cycle. LOAD/STORE -> MEM; else WB. If `take_branch`=1 and `target_pc[1:0]`!=0 -> TRAP, cause 10, PC not updated.
- MEM: `dmem_req_valid`=1, `dmem_we`=1 for STORE, held until `dmem_req_ready`. STORE -> WB; LOAD -> MWAIT.
- MWAIT: wait for `dmem_rvalid` -> WB.
- WB: `rf_we`=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD; 0 for BRANCH, STORE. PC <= `take_branch` latched in EXEC ? `target_pc` (latched) : `pc`+4 (mod 2^32). -> FETCH.
- HALT, TRAP: terminal; all request/strobe outputs 0; left only by reset.
- x0 writes are discarded by the register file, not here.

## Timing
- Reset (async assert, sync release): `pc`=RESET_PC, `inst`=32'h0000_0013, `alu_ctrl`=0, `rf_we`=0, `imem_req_valid`=0, `dmem_req_valid`=0, `dmem_we`=0, `halt`=0, `trap`=0, `trap_cause`=0, state FETCH; `imem_req_valid` rises the first cycle after release.
- Reset mid-instruction aborts it; no write, no PC update; late responses discarded.
- Zero-wait memories (ready same cycle, rvalid next): ALU/branch instr 5 cycles, store 6, load 7, FETCH-to-FETCH.
- Each wait cycle on `*_req_ready` or `*_rvalid` adds exactly one cycle.
- Request valids never drop before handshake; `imem_addr` stable while `imem_req_valid`=1.
- `rf_we` high exactly one cycle per writing instruction.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Test plan
- Reset release, zero-wait imem returns 32'h0010_0093 (addi x1,x0,1) -> `alu_ctrl`=0000, `rf_we` pulse at cycle 5, `pc`=32'h8000_0004.
- 32'h4020_80B3 (sub) with `imem_req_ready` low 3 cycles -> `alu_ctrl`=1000, `rf_we` at cycle 8, `imem_addr` stable during stall.
- Load 32'h0000_2103 with `dmem_rvalid` delayed 2 cycles -> `dmem_we`=0, `rf_we` at cycle 9; store 32'h0020_A023 -> `dmem_we`=1, no `rf_we`, 6 cycles.
- Branch with `take_branch`=1, `target_pc`=32'h8000_0100 -> no `rf_we`, next `imem_addr`=32'h8000_0100; `target_pc`=32'h8000_0102 -> `trap`=1, `trap_cause`=10.
- `inst`=32'hFFFF_FFFF -> `trap`=1, cause 01, no further requests; 32'h0010_0073 -> `halt`=1.
- Assert `reset` low during MWAIT, then pulse `dmem_rvalid` -> `pc`=RESET_PC, no `rf_we`, fetch restarts.
